// File: rtl/ecc_bridge_pkg.sv
// Shared types, flag encodings and SEC-DED helpers for the ECC memory bridge.
// Helpers work on the widest supported word; callers pass the real data width.
package ecc_bridge_pkg;

    localparam int unsigned MAX_DATA_W = 32;
    localparam int unsigned MAX_CODE_W = 39;

    localparam logic [2:0] FLAG_CLEAN  = 3'b001;
    localparam logic [2:0] FLAG_CORR   = 3'b010;
    localparam logic [2:0] FLAG_UNCORR = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_DECODE,
        S_SCRUB,
        S_RESP
    } state_t;

    // Smallest P with 2^P >= data_w + P + 1
    function automatic int unsigned calc_p(input int unsigned data_w);
        int unsigned p;
        p = 0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (p == 0 && (32'd1 << i) >= data_w + i + 32'd1) p = i;
        end
        return p;
    endfunction

    function automatic logic [MAX_CODE_W-1:0] secded_encode(input logic [MAX_DATA_W-1:0] data,
                                                            input int unsigned data_w);
        logic [MAX_CODE_W-1:0] cw;
        logic                  par;
        int unsigned           code_w;
        int unsigned           di;
        code_w = data_w + calc_p(data_w) + 32'd1;
        cw     = '0;
        di     = 0;
        for (int unsigned pos = 1; pos < MAX_CODE_W; pos++) begin
            if (pos < code_w && (pos & (pos - 32'd1)) != 32'd0) begin
                cw[pos] = data[di];
                di++;
            end
        end
        // Check bit 2^k covers every position whose index has bit k set
        for (int unsigned k = 0; k < 6; k++) begin
            par = 1'b0;
            for (int unsigned pos = 1; pos < MAX_CODE_W; pos++) begin
                if (pos < code_w && ((pos >> k) & 32'd1) != 32'd0 && pos != (32'd1 << k))
                    par = par ^ cw[pos];
            end
            if ((32'd1 << k) < code_w) cw[32'd1 << k] = par;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] secded_extract(input logic [MAX_CODE_W-1:0] cw,
                                                             input int unsigned data_w);
        logic [MAX_DATA_W-1:0] data;
        int unsigned           code_w;
        int unsigned           di;
        code_w = data_w + calc_p(data_w) + 32'd1;
        data   = '0;
        di     = 0;
        for (int unsigned pos = 1; pos < MAX_CODE_W; pos++) begin
            if (pos < code_w && (pos & (pos - 32'd1)) != 32'd0) begin
                data[di] = cw[pos];
                di++;
            end
        end
        return data;
    endfunction

endpackage

// File: rtl/ecc_mem_bridge_if.sv
// MCU-side request/response bus of the ECC memory bridge.
interface ecc_mem_bridge_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
) ();
    logic              mcu_req;
    logic              mcu_we;
    logic [ADDR_W-1:0] mcu_addr;
    logic [DATA_W-1:0] mcu_wdata;
    logic              mcu_ack;
    logic [DATA_W-1:0] mcu_rdata;
    logic [2:0]        flag_out;

    modport master (
        output mcu_req, mcu_we, mcu_addr, mcu_wdata,
        input  mcu_ack, mcu_rdata, flag_out
    );

    modport slave (
        input  mcu_req, mcu_we, mcu_addr, mcu_wdata,
        output mcu_ack, mcu_rdata, flag_out
    );
endinterface

// File: rtl/secded_decoder.sv
// Combinational SEC-DED decoder: one codeword in, corrected data and one-hot status out.
module secded_decoder
    import ecc_bridge_pkg::*;
#(
    parameter  int unsigned DATA_W = 16,
    localparam int unsigned P      = calc_p(DATA_W),
    localparam int unsigned CODE_W = DATA_W + P + 1
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [DATA_W-1:0] data_o,
    output logic [2:0]        status_o
);

    logic [P-1:0]      syn;
    logic              par;
    logic [CODE_W-1:0] fixed;

    // A syndrome beyond the last position can only come from a multi-bit error
    always_comb begin
        syn = '0;
        for (int unsigned pos = 1; pos < CODE_W; pos++) begin
            if (code_i[pos]) syn = syn ^ P'(pos);
        end
        par      = ^code_i;
        fixed    = code_i;
        status_o = FLAG_CLEAN;
        if (par) begin
            if (32'(syn) < CODE_W) begin
                fixed    = code_i ^ (CODE_W'(1) << syn);
                status_o = FLAG_CORR;
            end else begin
                status_o = FLAG_UNCORR;
            end
        end else if (syn != '0) begin
            status_o = FLAG_UNCORR;
        end
        data_o = DATA_W'(secded_extract(MAX_CODE_W'(fixed), DATA_W));
    end

endmodule

// File: rtl/ecc_mem_bridge.sv
// MCU-to-memory bridge: SEC-DED encode on write to NUM_CH replicated channels,
// best-copy selection on read with optional scrub write-back and saturating error counters.
module ecc_mem_bridge
    import ecc_bridge_pkg::*;
#(
    parameter  int unsigned DATA_W  = 16,
    parameter  int unsigned ADDR_W  = 10,
    parameter  int unsigned NUM_CH  = 2,
    parameter  int unsigned MEM_LAT = 1,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned CODE_W  = DATA_W + calc_p(DATA_W) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    ecc_mem_bridge_if.slave          mcu,
    input  logic                     scrub_en,
    input  logic [NUM_CH-1:0]        inj_ch,
    input  logic [CODE_W-1:0]        inj_mask,
    output logic [NUM_CH-1:0]        mem_cs,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [NUM_CH*CODE_W-1:0] mem_wdata,
    input  logic [NUM_CH*CODE_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]         corr_cnt,
    output logic [CNT_W-1:0]         uncorr_cnt
);

    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t                    state_q, state_d;
    logic [LAT_W-1:0]          lat_q, lat_d;
    logic [NUM_CH*CODE_W-1:0]  cap_q, cap_d;
    logic [NUM_CH-1:0]         cs_q, cs_d;
    logic                      mwe_q, mwe_d;
    logic [ADDR_W-1:0]         maddr_q, maddr_d;
    logic [NUM_CH*CODE_W-1:0]  mwdata_q, mwdata_d;
    logic                      ack_q, ack_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;
    logic [2:0]                flag_q, flag_d;
    logic [CNT_W-1:0]          corr_q, corr_d;
    logic [CNT_W-1:0]          uncorr_q, uncorr_d;

    logic [DATA_W-1:0]         dec_data [NUM_CH];
    logic [2:0]                dec_stat [NUM_CH];
    logic [DATA_W-1:0]         sel_data, clean_data, corr_data;
    logic [2:0]                sel_flag;
    logic                      found_clean, found_corr, all_clean, all_uncorr;
    logic [CODE_W-1:0]         wr_cw, scrub_cw;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
        secded_decoder #(.DATA_W(DATA_W)) u_dec (
            .code_i   (cap_q[g*CODE_W +: CODE_W]),
            .data_o   (dec_data[g]),
            .status_o (dec_stat[g])
        );
    end

    assign wr_cw    = CODE_W'(secded_encode(MAX_DATA_W'(mcu.mcu_wdata), DATA_W));
    assign scrub_cw = CODE_W'(secded_encode(MAX_DATA_W'(sel_data), DATA_W));

    // Prefer the lowest clean copy, then the lowest corrected one, else channel 0 raw
    always_comb begin
        clean_data  = dec_data[0];
        corr_data   = dec_data[0];
        found_clean = 1'b0;
        found_corr  = 1'b0;
        all_clean   = 1'b1;
        all_uncorr  = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (dec_stat[i] != FLAG_CLEAN)  all_clean  = 1'b0;
            if (dec_stat[i] != FLAG_UNCORR) all_uncorr = 1'b0;
            if (!found_clean && dec_stat[i] == FLAG_CLEAN) begin
                clean_data  = dec_data[i];
                found_clean = 1'b1;
            end
            if (!found_corr && dec_stat[i] == FLAG_CORR) begin
                corr_data  = dec_data[i];
                found_corr = 1'b1;
            end
        end
        sel_data = found_clean ? clean_data : (found_corr ? corr_data : dec_data[0]);
        sel_flag = all_clean ? FLAG_CLEAN : (all_uncorr ? FLAG_UNCORR : FLAG_CORR);
    end

    // Memory strobes are registered, so they are raised on the edge entering WRITE/READ/SCRUB
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        cap_d    = cap_q;
        cs_d     = '0;
        mwe_d    = 1'b0;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        flag_d   = flag_q;
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        case (state_q)
            S_IDLE: begin
                if (mcu.mcu_req) begin
                    maddr_d = mcu.mcu_addr;
                    cs_d    = '1;
                    if (mcu.mcu_we) begin
                        state_d = S_WRITE;
                        mwe_d   = 1'b1;
                        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                            mwdata_d[ch*CODE_W +: CODE_W] = wr_cw ^ (inj_ch[ch] ? inj_mask : '0);
                        end
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_RESP;
                ack_d   = 1'b1;
            end
            S_READ: begin
                state_d = S_WAIT;
                lat_d   = '0;
            end
            S_WAIT: begin
                if (lat_q == LAT_W'(MEM_LAT - 1)) begin
                    state_d = S_DECODE;
                    cap_d   = mem_rdata;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_DECODE: begin
                rdata_d = sel_data;
                flag_d  = sel_flag;
                if (sel_flag == FLAG_CORR && corr_q != '1)     corr_d   = corr_q + CNT_W'(1);
                if (sel_flag == FLAG_UNCORR && uncorr_q != '1) uncorr_d = uncorr_q + CNT_W'(1);
                if (scrub_en && sel_flag == FLAG_CORR) begin
                    state_d  = S_SCRUB;
                    cs_d     = '1;
                    mwe_d    = 1'b1;
                    mwdata_d = {NUM_CH{scrub_cw}};
                end else begin
                    state_d = S_RESP;
                    ack_d   = 1'b1;
                end
            end
            S_SCRUB: begin
                state_d = S_RESP;
                ack_d   = 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lat_q    <= '0;
            cap_q    <= '0;
            cs_q     <= '0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            flag_q   <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            cap_q    <= cap_d;
            cs_q     <= cs_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            flag_q   <= flag_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
        end
    end

    assign mem_cs        = cs_q;
    assign mem_we        = mwe_q;
    assign mem_addr      = maddr_q;
    assign mem_wdata     = mwdata_q;
    assign mcu.mcu_ack   = ack_q;
    assign mcu.mcu_rdata = rdata_q;
    assign mcu.flag_out  = flag_q;
    assign corr_cnt      = corr_q;
    assign uncorr_cnt    = uncorr_q;

endmodule

// File: tb/tb_ecc_mem_bridge.sv
// Directed bench for ecc_mem_bridge: vector table of transactions plus
// hand-written reset-abort and counter-saturation sequences against a 2-channel memory model.
module tb_ecc_mem_bridge;
    import ecc_bridge_pkg::*;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 10;
    localparam int unsigned NCH  = 2;
    localparam int unsigned CW   = 22;
    localparam int unsigned CNTW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ecc_mem_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) mcu_if ();

    logic              scrub_en;
    logic [NCH-1:0]    inj_ch;
    logic [CW-1:0]     inj_mask;
    logic [NCH-1:0]    mem_cs;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [NCH*CW-1:0] mem_wdata;
    logic [NCH*CW-1:0] mem_rdata;
    logic [CNTW-1:0]   corr_cnt;
    logic [CNTW-1:0]   uncorr_cnt;

    ecc_mem_bridge #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .MEM_LAT(1), .CNT_W(CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mcu        (mcu_if),
        .scrub_en   (scrub_en),
        .inj_ch     (inj_ch),
        .inj_mask   (inj_mask),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    // Two-channel memory with one-cycle registered read
    logic [CW-1:0] mem [NCH][1024];
    int            wr_cnt = 0;
    logic [AW-1:0] last_wr_addr;
    logic [CW-1:0] last_cw [NCH];

    always @(posedge clk) begin
        if (mem_cs != '0 && mem_we) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_addr;
        end
        for (int c = 0; c < NCH; c++) begin
            if (mem_cs[c]) begin
                if (mem_we) begin
                    mem[c][mem_addr] <= mem_wdata[c*CW +: CW];
                    last_cw[c]       <= mem_wdata[c*CW +: CW];
                end else begin
                    mem_rdata[c*CW +: CW] <= mem[c][mem_addr];
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one transaction; returns the ack cycle counted from the accept edge (-1 on timeout)
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [NCH-1:0] ich, input logic [CW-1:0] imask, input logic scr,
                           output int lat);
        int cyc;
        mcu_if.mcu_we    = we;
        mcu_if.mcu_addr  = addr;
        mcu_if.mcu_wdata = wdata;
        inj_ch           = ich;
        inj_mask         = imask;
        scrub_en         = scr;
        mcu_if.mcu_req   = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        lat = -1;
        while (cyc <= 20 && lat < 0) begin
            if (mcu_if.mcu_ack) lat = cyc;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        mcu_if.mcu_req = 1'b0;
    endtask

    typedef struct {
        logic           we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [NCH-1:0] ich;
        logic [CW-1:0]  imask;
        logic           scr;
        logic [DW-1:0]  exp_rdata;
        logic [2:0]     exp_flag;
        int             exp_lat;
        logic [CNTW-1:0] exp_corr;
        logic [CNTW-1:0] exp_uncorr;
        int             exp_wr;
        logic           chk_cw;
        logic [CW-1:0]  cw0;
        logic [CW-1:0]  cw1;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int wr0;
        bit ack_seen;

        mcu_if.mcu_req   = 1'b0;
        mcu_if.mcu_we    = 1'b0;
        mcu_if.mcu_addr  = '0;
        mcu_if.mcu_wdata = '0;
        scrub_en = 1'b0;
        inj_ch   = '0;
        inj_mask = '0;

        // encode(0x1234)=0x054742, encode(0x0001)=0x00000F; injected copies flip the masked bits
        tbl[0] = '{1'b1, 10'd3,   16'hA5C3, 2'b00, 22'h0,     1'b0, 16'h0000, 3'b000,      2, 2'd0, 2'd0, 1, 1'b0, 22'h0,      22'h0};
        tbl[1] = '{1'b0, 10'd3,   16'h0000, 2'b00, 22'h0,     1'b0, 16'hA5C3, FLAG_CLEAN,  4, 2'd0, 2'd0, 0, 1'b0, 22'h0,      22'h0};
        tbl[2] = '{1'b1, 10'd5,   16'h1234, 2'b01, 22'h80,    1'b0, 16'hA5C3, FLAG_CLEAN,  2, 2'd0, 2'd0, 1, 1'b1, 22'h0547C2, 22'h054742};
        tbl[3] = '{1'b0, 10'd5,   16'h0000, 2'b00, 22'h0,     1'b0, 16'h1234, FLAG_CORR,   4, 2'd1, 2'd0, 0, 1'b0, 22'h0,      22'h0};
        tbl[4] = '{1'b0, 10'd5,   16'h0000, 2'b00, 22'h0,     1'b1, 16'h1234, FLAG_CORR,   5, 2'd2, 2'd0, 1, 1'b1, 22'h054742, 22'h054742};
        tbl[5] = '{1'b0, 10'd5,   16'h0000, 2'b00, 22'h0,     1'b0, 16'h1234, FLAG_CLEAN,  4, 2'd2, 2'd0, 0, 1'b0, 22'h0,      22'h0};
        tbl[6] = '{1'b1, 10'd9,   16'hFFFF, 2'b11, 22'h204,   1'b0, 16'h1234, FLAG_CLEAN,  2, 2'd2, 2'd0, 1, 1'b0, 22'h0,      22'h0};
        tbl[7] = '{1'b0, 10'd9,   16'h0000, 2'b00, 22'h0,     1'b1, 16'hFFEF, FLAG_UNCORR, 4, 2'd2, 2'd1, 0, 1'b0, 22'h0,      22'h0};
        tbl[8] = '{1'b1, 10'h3FF, 16'h0001, 2'b10, 22'h1,     1'b0, 16'hFFEF, FLAG_UNCORR, 2, 2'd2, 2'd1, 1, 1'b1, 22'h00000F, 22'h00000E};
        tbl[9] = '{1'b0, 10'h3FF, 16'h0000, 2'b00, 22'h0,     1'b0, 16'h0001, FLAG_CORR,   4, 2'd3, 2'd1, 0, 1'b0, 22'h0,      22'h0};

        // Power-on reset
        #2 rst = 1'b1;
        #1;
        check("rst_cs",     32'(mem_cs), 32'h0);
        check("rst_we",     32'(mem_we), 32'h0);
        check("rst_ack",    32'(mcu_if.mcu_ack), 32'h0);
        check("rst_rdata",  32'(mcu_if.mcu_rdata), 32'h0);
        check("rst_flag",   32'(mcu_if.flag_out), 32'h0);
        check("rst_cnt",    32'({corr_cnt, uncorr_cnt}), 32'h0);
        check("rst_maddr",  32'(mem_addr), 32'h0);
        check("rst_wdata",  32'(mem_wdata[31:0]), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            wr0 = wr_cnt;
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ich, tbl[i].imask, tbl[i].scr, lat);
            check($sformatf("v%0d_lat", i),    32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("v%0d_rdata", i),  32'(mcu_if.mcu_rdata), 32'(tbl[i].exp_rdata));
            check($sformatf("v%0d_flag", i),   32'(mcu_if.flag_out), 32'(tbl[i].exp_flag));
            check($sformatf("v%0d_corr", i),   32'(corr_cnt), 32'(tbl[i].exp_corr));
            check($sformatf("v%0d_uncorr", i), 32'(uncorr_cnt), 32'(tbl[i].exp_uncorr));
            check($sformatf("v%0d_nwr", i),    32'(wr_cnt - wr0), 32'(tbl[i].exp_wr));
            check($sformatf("v%0d_ackdrop", i), 32'(mcu_if.mcu_ack), 32'h0);
            if (tbl[i].chk_cw) begin
                check($sformatf("v%0d_cw0", i),   32'(last_cw[0]), 32'(tbl[i].cw0));
                check($sformatf("v%0d_cw1", i),   32'(last_cw[1]), 32'(tbl[i].cw1));
                check($sformatf("v%0d_waddr", i), 32'(last_wr_addr), 32'(tbl[i].addr));
            end
        end

        // Reset in the middle of a write cycle: strobes drop at once, nothing is written
        wr0 = wr_cnt;
        mcu_if.mcu_we    = 1'b1;
        mcu_if.mcu_addr  = 10'd12;
        mcu_if.mcu_wdata = 16'h0F0F;
        inj_ch           = '0;
        mcu_if.mcu_req   = 1'b1;
        @(posedge clk); #1;
        check("rstw_we_before", 32'(mem_we), 32'h1);
        rst = 1'b1;
        #1;
        check("rstw_cs", 32'(mem_cs), 32'h0);
        check("rstw_we", 32'(mem_we), 32'h0);
        mcu_if.mcu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rstw_nwr", 32'(wr_cnt - wr0), 32'h0);

        // Reset during the WAIT cycle of a read aborts it without an ack
        mcu_if.mcu_we   = 1'b0;
        mcu_if.mcu_addr = 10'd3;
        mcu_if.mcu_req  = 1'b1;
        @(posedge clk); #1;
        check("rstr_cs_read", 32'(mem_cs), 32'h3);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rstr_cs",    32'(mem_cs), 32'h0);
        check("rstr_ack",   32'(mcu_if.mcu_ack), 32'h0);
        check("rstr_corr",  32'(corr_cnt), 32'h0);
        check("rstr_uncorr", 32'(uncorr_cnt), 32'h0);
        check("rstr_flag",  32'(mcu_if.flag_out), 32'h0);
        check("rstr_rdata", 32'(mcu_if.mcu_rdata), 32'h0);
        mcu_if.mcu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        ack_seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (mcu_if.mcu_ack) ack_seen = 1'b1;
        end
        check("rstr_no_ack", 32'(ack_seen), 32'h0);

        // Normal operation resumes after the abort
        run_txn(1'b0, 10'd3, 16'h0, 2'b00, 22'h0, 1'b0, lat);
        check("post_lat",   32'(lat), 32'd4);
        check("post_rdata", 32'(mcu_if.mcu_rdata), 32'hA5C3);
        check("post_flag",  32'(mcu_if.flag_out), 32'(FLAG_CLEAN));

        // Corrected reads of the still-damaged copy drive corr_cnt into saturation
        for (int k = 1; k <= 5; k++) begin
            run_txn(1'b0, 10'h3FF, 16'h0, 2'b00, 22'h0, 1'b0, lat);
            check($sformatf("sat%0d_corr", k),  32'(corr_cnt), (k > 3) ? 32'd3 : 32'(k));
            check($sformatf("sat%0d_flag", k),  32'(mcu_if.flag_out), 32'(FLAG_CORR));
            check($sformatf("sat%0d_rdata", k), 32'(mcu_if.mcu_rdata), 32'h0001);
        end
        check("sat_uncorr", 32'(uncorr_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
